// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared opcode, immediate-range and format definitions for the RV32I instruction encoder.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int I_IMM_MIN = -2048;
    localparam int I_IMM_MAX = 2047;
    localparam int S_IMM_MIN = -2048;
    localparam int S_IMM_MAX = 2047;
    localparam int B_IMM_MIN = -4096;
    localparam int B_IMM_MAX = 4094;
    localparam int J_IMM_MIN = -1048576;
    localparam int J_IMM_MAX = 1048574;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                      f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder_fifo.sv
// Synchronous FIFO with combinational head read; head data reads as zero while empty.
module rv32i_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: pack/check stage register feeding an output FIFO.
// Define IMM_RANGE_CHECK_EN to enable immediate range/alignment flagging (out_err, err_count).
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IMM_RANGE_CHECK_EN
    localparam int FW = 33;
`else
    localparam int FW = 32;
`endif

    fmt_e             fmt;
    logic [31:0]      enc_instr;
    logic             accept;
    logic             stage_vld_q;
    logic [31:0]      stage_instr_q;
    logic [CNT_W-1:0] enc_cnt_q;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occ;

    assign fmt = fmt_of(in_opcode);

    always_comb begin
        enc_instr = NOP_INSTR;
        case (fmt)
            FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
            default: enc_instr = NOP_INSTR;
        endcase
    end

    // Stage and FIFO occupancy together bound acceptance, so the stage can always drain.
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, stage_vld_q};
    assign in_ready = rst_n && !fifo_full && (occ < (CW+1)'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_q <= 1'b0;
            enc_cnt_q   <= '0;
        end else begin
            stage_vld_q <= accept;
            if (accept && (enc_cnt_q != {CNT_W{1'b1}})) enc_cnt_q <= enc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) stage_instr_q <= enc_instr;
    end

    assign enc_count = enc_cnt_q;

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    logic               enc_err;
    logic               stage_err_q;
    logic [CNT_W-1:0]   err_cnt_q;

    assign imm_s = in_imm;

    always_comb begin
        enc_err = 1'b0;
        case (fmt)
            FMT_I:   enc_err = (imm_s < I_IMM_MIN) || (imm_s > I_IMM_MAX);
            FMT_S:   enc_err = (imm_s < S_IMM_MIN) || (imm_s > S_IMM_MAX);
            FMT_B:   enc_err = (imm_s < B_IMM_MIN) || (imm_s > B_IMM_MAX) || in_imm[0];
            FMT_U:   enc_err = (in_imm[11:0] != 12'h000);
            FMT_J:   enc_err = (imm_s < J_IMM_MIN) || (imm_s > J_IMM_MAX) || in_imm[0];
            FMT_BAD: enc_err = 1'b1;
            default: enc_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) stage_err_q <= enc_err;
    end

    // Errors are counted as their word enters the FIFO, one edge after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (stage_vld_q && stage_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign fifo_wdata = {stage_instr_q, stage_err_q};
    assign out_instr  = fifo_rdata[FW-1:1];
    assign out_err    = fifo_rdata[0];
    assign err_count  = err_cnt_q;
`else
    assign fifo_wdata = stage_instr_q;
    assign out_instr  = fifo_rdata;
    assign out_err    = 1'b0;
    assign err_count  = '0;
`endif

    rv32i_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (stage_vld_q),
        .wdata_i (fifo_wdata),
        .pop_i   (out_valid && out_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: encodings, latency, backpressure, streaming, reset.
module tb_rv32i_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;
    int exp_enc = 0;
    int exp_err = 0;

    rv32i_instr_encoder #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // ADDI x1,x0,k reference word, used to tag stream words by index.
    function automatic logic [31:0] addi_w(input int k);
        logic [31:0] kv;
        kv = k;
        return {kv[11:0], 5'd0, 3'd0, 5'd1, 7'b0010011};
    endfunction

    // Single word through an empty pipeline; entered and left at #1 after a rising edge.
    task automatic one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input bit bad);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_enc++;
        chk({tag, "_valid_n"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        if (bad && CHK) exp_err++;
        chk({tag, "_valid_n1"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, bad && CHK});
        chk({tag, "_enc_cnt"}, {16'd0, enc_count}, exp_enc);
        chk({tag, "_err_cnt"}, {16'd0, err_count}, exp_err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int  sent;
        int  got;
        int  accn;
        bit  acc;
        bit  pop;
        bit  contig;
        logic [31:0] pv;

        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        one("addi_m1",   7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
        one("addi_2047", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,     32'h7FF00093, 1'b0);
        one("addi_m2048",7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        one("addi_2048", 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80010093, 1'b1);
        one("sub",       7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h7FFFFFFF, 32'h402081B3, 1'b0);
        one("sw_m4",     7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE312E23, 1'b0);
        one("beq_8",     7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,        32'h00208463, 1'b0);
        one("beq_4096",  7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,     32'h80208063, 1'b1);
        one("beq_3",     7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,        32'h00208163, 1'b1);
        one("jal_m4",    7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0);
        one("lui",       7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        one("lui_low",   7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1);
        one("unknown",   7'b1111111, 5'd7, 5'd3, 5'd4, 3'd5, 7'h11, 32'h00000123, 32'h00000013, 1'b1);

        // Backpressure: consumer stalled, six words offered.
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, sent);
            in_valid = (sent < 6);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin sent++; exp_enc++; end
        end
        chk("bp_accepted", sent, 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head", out_instr, addi_w(0));
        @(posedge clk); #1;
        chk("bp_head_stable", out_instr, addi_w(0));
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, sent);
            in_valid = (sent < 6);
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            pv  = out_instr;
            @(posedge clk); #1;
            if (acc) begin sent++; exp_enc++; end
            if (pop) begin
                chk($sformatf("bp_order_%0d", got), pv, addi_w(got));
                got++;
            end
        end
        in_valid = 1'b0;
        chk("bp_popped", got, 32'd6);
        chk("bp_sent", sent, 32'd6);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_enc_count", {16'd0, enc_count}, exp_enc);

        // Streaming at one word per cycle.
        out_ready = 1'b1;
        got = 0;
        accn = 0;
        contig = 1'b1;
        for (int c = 0; c < 14; c++) begin
            drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, c);
            in_valid = (c < 10);
            acc = in_valid && in_ready;
            if (c >= 2 && c < 12 && !out_valid) contig = 1'b0;
            pop = out_valid && out_ready;
            pv  = out_instr;
            @(posedge clk); #1;
            if (acc) begin accn++; exp_enc++; end
            if (pop) begin
                chk($sformatf("st_order_%0d", got), pv, addi_w(got));
                got++;
            end
        end
        in_valid = 1'b0;
        chk("st_accepted", accn, 32'd10);
        chk("st_popped", got, 32'd10);
        chk("st_contiguous", {31'd0, contig}, 32'd1);
        chk("st_enc_count", {16'd0, enc_count}, exp_enc);

        // Reset asserted mid-stream.
        for (int c = 0; c < 3; c++) begin
            drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 100 + c);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("mr_out_valid_pre", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_enc = 0;
        exp_err = 0;
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_out_instr", out_instr, 32'd0);
        chk("mr_enc_count", {16'd0, enc_count}, 32'd0);
        chk("mr_err_count", {16'd0, err_count}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_after_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_after_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        one("unknown_post", 7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
